// File: rtl/gtp_blk_rcv_pkg.sv
// Shared definitions for the GTP block receiver: control-word field layout and FSM encoding.
package gtp_blk_rcv_pkg;

  localparam int CW_FLAG   = 15;
  localparam int CW_LEN_HI = 14;
  localparam int CW_LEN_LO = 6;
  localparam int LEN_W     = CW_LEN_HI - CW_LEN_LO + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [LEN_W-1:0] cw_len(input logic [15:0] w);
    return w[CW_LEN_HI:CW_LEN_LO];
  endfunction

endpackage

// File: rtl/blk_sdp_ram.sv
// Simple dual-port block buffer: synchronous write, registered read that holds while i_re is low.
module blk_sdp_ram #(
  parameter int AW = 11,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gtp_blk_rcv.sv
// GTP lane block receiver: buffers whole blocks and releases only committed, length-consistent ones.
// Optional statistics outputs blk_cnt/drop_cnt are built when GTP_BLK_RCV_STAT_EN is defined.
module gtp_blk_rcv
  import gtp_blk_rcv_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_data,
  input  logic        rx_kchar,
  output logic [15:0] dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        err_undr,
  output logic        err_ovr,
  output logic        err_full,
`ifdef GTP_BLK_RCV_STAT_EN
  output logic [15:0] blk_cnt,
  output logic [15:0] drop_cnt,
`endif
  output logic [1:0]  dbg_state
);

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_wr_ptr, r_cmt_ptr, r_rd_ptr;
  logic [AW-1:0]    w_wr_ptr_nxt, w_cmt_ptr_nxt, w_waddr, w_waddr_p1;
  logic [LEN_W-1:0] r_rem, w_rem_nxt, w_len;
  logic             w_vld, w_cw, w_full, w_we;
  logic [16:0]      w_wdata;
  logic             w_undr, w_ovr, w_fullp;
  logic             r_err_undr, r_err_ovr, r_err_full;

  assign w_vld      = ~rx_kchar;
  assign w_cw       = rx_data[CW_FLAG];
  assign w_len      = cw_len(rx_data);
  // A control word always lands at cmt_ptr: in IDLE/DROP wr_ptr already equals it, in LOAD it is the rewind.
  assign w_waddr    = w_cw ? r_cmt_ptr : r_wr_ptr;
  assign w_waddr_p1 = w_waddr + AW'(1);
  assign w_full     = (w_waddr_p1 == r_rd_ptr);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_vld) begin
      if (w_cw) begin
        if (w_full)          w_state_nxt = ST_DROP;
        else if (w_len == '0) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_LOAD;
      end else if (r_state == ST_LOAD) begin
        if (w_full)                     w_state_nxt = ST_DROP;
        else if (r_rem == LEN_W'(1))    w_state_nxt = ST_IDLE;
      end
    end
  end

  always_comb begin
    w_we          = 1'b0;
    w_wdata       = {1'b0, rx_data};
    w_wr_ptr_nxt  = r_wr_ptr;
    w_cmt_ptr_nxt = r_cmt_ptr;
    w_rem_nxt     = r_rem;
    w_undr        = 1'b0;
    w_ovr         = 1'b0;
    w_fullp       = 1'b0;
    if (w_vld) begin
      if (w_cw) begin
        w_undr = (r_state == ST_LOAD);
        if (w_full) begin
          w_fullp      = 1'b1;
          w_wr_ptr_nxt = r_cmt_ptr;
        end else begin
          w_we         = 1'b1;
          w_wdata      = {(w_len == '0), rx_data};
          w_wr_ptr_nxt = w_waddr_p1;
          w_rem_nxt    = w_len;
          if (w_len == '0) w_cmt_ptr_nxt = w_waddr_p1;
        end
      end else if (r_state == ST_LOAD) begin
        if (w_full) begin
          w_fullp      = 1'b1;
          w_wr_ptr_nxt = r_cmt_ptr;
        end else begin
          w_we         = 1'b1;
          w_wdata      = {(r_rem == LEN_W'(1)), rx_data};
          w_wr_ptr_nxt = w_waddr_p1;
          w_rem_nxt    = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) w_cmt_ptr_nxt = w_waddr_p1;
        end
      end else if (r_state == ST_IDLE) begin
        w_ovr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rem      <= '0;
      r_err_undr <= 1'b0;
      r_err_ovr  <= 1'b0;
      r_err_full <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_cmt_ptr  <= w_cmt_ptr_nxt;
      r_rem      <= w_rem_nxt;
      r_err_undr <= w_undr;
      r_err_ovr  <= w_ovr;
      r_err_full <= w_fullp;
    end
  end

  // Read side. dout_valid/dout_ready: a word transfers on every clock where both are high;
  // while dout_valid is high and dout_ready is low, dout/sop/eop are held unchanged.
  logic        r_ram_vld, r_out_vld;
  logic [16:0] r_out, w_ram_q;
  logic        w_rd_en, w_out_load;

  assign w_out_load = r_ram_vld & (~r_out_vld | dout_ready);
  assign w_rd_en    = (r_rd_ptr != r_cmt_ptr) & (~r_ram_vld | w_out_load);

  blk_sdp_ram #(.AW(AW), .DW(17)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr  <= '0;
      r_ram_vld <= 1'b0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_ram_vld <= w_rd_en | (r_ram_vld & ~w_out_load);
      if (w_out_load) begin
        r_out     <= w_ram_q;
        r_out_vld <= 1'b1;
      end else if (dout_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign dout       = r_out[15:0];
  assign dout_sop   = r_out[CW_FLAG];
  assign dout_eop   = r_out[16];
  assign dout_valid = r_out_vld;
  assign err_undr   = r_err_undr;
  assign err_ovr    = r_err_ovr;
  assign err_full   = r_err_full;
  assign dbg_state  = r_state;

`ifdef GTP_BLK_RCV_STAT_EN
  logic [15:0] r_blk_cnt, r_drop_cnt;
  logic        w_commit;
  logic [1:0]  w_drops;
  logic [16:0] w_drop_sum;

  // A truncated block and a full-buffer drop can both happen on one word.
  assign w_commit   = (w_cmt_ptr_nxt != r_cmt_ptr);
  assign w_drops    = {1'b0, w_undr} + {1'b0, w_fullp};
  assign w_drop_sum = {1'b0, r_drop_cnt} + {15'd0, w_drops};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_commit && r_blk_cnt != 16'hFFFF) r_blk_cnt <= r_blk_cnt + 16'd1;
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign blk_cnt  = r_blk_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_gtp_blk_rcv.sv
// Bench for gtp_blk_rcv: directed block cases plus randomized block streams against a block-level model.
module tb_gtp_blk_rcv;
  import gtp_blk_rcv_pkg::*;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rx_data, dout;
  logic        rx_kchar, dout_sop, dout_eop, dout_valid, dout_ready;
  logic        err_undr, err_ovr, err_full;
  logic [1:0]  dbg_state;

  logic [15:0] s_rx_data, s_dout;
  logic        s_rx_kchar, s_dout_sop, s_dout_eop, s_dout_valid, s_dout_ready;
  logic        s_err_undr, s_err_ovr, s_err_full;
  logic [1:0]  s_dbg_state;

`ifdef GTP_BLK_RCV_STAT_EN
  logic [15:0] blk_cnt, drop_cnt, s_blk_cnt, s_drop_cnt;
`endif

  gtp_blk_rcv #(.AW(11)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_kchar(rx_kchar),
    .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .err_undr(err_undr), .err_ovr(err_ovr), .err_full(err_full),
`ifdef GTP_BLK_RCV_STAT_EN
    .blk_cnt(blk_cnt), .drop_cnt(drop_cnt),
`endif
    .dbg_state(dbg_state)
  );

  gtp_blk_rcv #(.AW(4)) dut_s (
    .clk(clk), .reset(reset), .rx_data(s_rx_data), .rx_kchar(s_rx_kchar),
    .dout(s_dout), .dout_sop(s_dout_sop), .dout_eop(s_dout_eop), .dout_valid(s_dout_valid),
    .dout_ready(s_dout_ready), .err_undr(s_err_undr), .err_ovr(s_err_ovr), .err_full(s_err_full),
`ifdef GTP_BLK_RCV_STAT_EN
    .blk_cnt(s_blk_cnt), .drop_cnt(s_drop_cnt),
`endif
    .dbg_state(s_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];
  logic [16:0] s_exp_q[$];
  int exp_undr = 0, exp_ovr = 0;
  int cnt_undr = 0, cnt_ovr = 0, cnt_full = 0;
  int s_cnt_full = 0, s_cnt_other = 0;
  bit open_blk = 1'b0;
  bit rdy_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- output monitors ----------------
  logic        hold_pend = 1'b0;
  logic [17:0] hold_val;
  logic [16:0] mon_e, s_mon_e;

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (err_undr)   cnt_undr++;
      if (err_ovr)    cnt_ovr++;
      if (err_full)   cnt_full++;
      if (s_err_full) s_cnt_full++;
      if (s_err_undr | s_err_ovr) s_cnt_other++;
      if (hold_pend)
        check("hold", {dout_valid, dout_sop, dout_eop, dout}, {1'b1, hold_val});
      hold_pend = dout_valid & ~dout_ready;
      hold_val  = {dout_sop, dout_eop, dout};
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("out_unexpected", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          check("out_word", {dout_sop, dout_eop, dout}, {mon_e[15], mon_e[16], mon_e[15:0]});
        end
      end
      if (s_dout_valid && s_dout_ready) begin
        if (s_exp_q.size() == 0) check("s_out_unexpected", s_exp_q.size(), 1);
        else begin
          s_mon_e = s_exp_q.pop_front();
          check("s_out_word", {s_dout_sop, s_dout_eop, s_dout}, {s_mon_e[15], s_mon_e[16], s_mon_e[15:0]});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) dout_ready = ($urandom_range(0, 99) < 85);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] d, input logic k, input bit sm);
    @(posedge clk); #1;
    rx_kchar   = 1'b1;
    s_rx_kchar = 1'b1;
    if (sm) begin s_rx_data = d; s_rx_kchar = k; end
    else    begin rx_data   = d; rx_kchar   = k; end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(16'h0000, 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] mk_cw(input int len, input int src);
    return {1'b1, len[8:0], src[5:0]};
  endfunction

  // Sends CW(len) then n_data payload words with random commas; a block reaches the
  // expected queue only if it is complete and the bench expects it to fit (keep).
  task automatic send_block(input int len, input int n_data, input int comma_pct,
                            input bit sm, input bit keep);
    logic [16:0] blk[$];
    logic [15:0] w;
    w = mk_cw(len, $urandom_range(0, 63));
    if (!sm && open_blk) exp_undr++;
    blk.push_back({(len == 0), w});
    drive(w, 1'b0, sm);
    for (int i = 0; i < n_data; i++) begin
      while ($urandom_range(0, 99) < comma_pct) drive(16'($urandom), 1'b1, sm);
      w = {1'b0, 15'($urandom)};
      blk.push_back({(i == len - 1), w});
      drive(w, 1'b0, sm);
    end
    if (!sm) open_blk = (n_data < len);
    if (n_data == len && keep) begin
      for (int i = 0; i < blk.size(); i++) begin
        if (sm) s_exp_q.push_back(blk[i]);
        else    exp_q.push_back(blk[i]);
      end
    end
  endtask

  task automatic send_stray(input int n);
    for (int i = 0; i < n; i++) begin
      drive({1'b0, 15'($urandom)}, 1'b0, 1'b0);
      exp_ovr++;
    end
  endtask

  task automatic wait_drain(input bit sm, input int budget);
    int c;
    c = 0;
    idle(1);
    while ((sm ? s_exp_q.size() : exp_q.size()) != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(sm ? "s_drain" : "drain", sm ? s_exp_q.size() : exp_q.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_undr"}, cnt_undr, exp_undr);
    check({tag, "_ovr"},  cnt_ovr,  exp_ovr);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int r, len;
    rx_data = '0; rx_kchar = 1'b1; dout_ready = 1'b0;
    s_rx_data = '0; s_rx_kchar = 1'b1; s_dout_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {dout_valid, s_dout_valid}, 2'b00);
    check("rst_dout", {dout_sop, dout_eop, dout}, 18'h0);
    check("rst_err", {err_undr, err_ovr, err_full}, 3'b000);
    check("rst_state", dbg_state, ST_IDLE);

    dout_ready = 1'b1;
    send_block(3, 3, 0, 1'b0, 1'b1);
    wait_drain(1'b0, 200);
    check_errs("basic");

    send_block(5, 2, 0, 1'b0, 1'b1);
    send_block(0, 0, 0, 1'b0, 1'b1);
    wait_drain(1'b0, 200);
    check_errs("trunc");

    drive(16'h0123, 1'b0, 1'b0);
    exp_ovr++;
    wait_drain(1'b0, 200);
    check_errs("stray");

    send_block(4, 4, 60, 1'b0, 1'b1);
    wait_drain(1'b0, 200);
    check_errs("comma");

    send_block(511, 511, 5, 1'b0, 1'b1);
    wait_drain(1'b0, 2000);
    check_errs("maxlen");

    send_block(5, 2, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; rx_kchar = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    open_blk = 1'b0;
    @(negedge clk);
    check("rst_mid_state", dbg_state, ST_IDLE);
    send_block(1, 1, 0, 1'b0, 1'b1);
    wait_drain(1'b0, 200);
    check_errs("rst_mid");

    // Depth-16 instance with a stalled consumer: the second 11-word block cannot fit.
    s_dout_ready = 1'b0;
    send_block(10, 10, 0, 1'b1, 1'b1);
    send_block(10, 10, 0, 1'b1, 1'b0);
    idle(5);
    s_dout_ready = 1'b1;
    wait_drain(1'b1, 200);
    check("full_pulse", s_cnt_full, 1);
    send_block(2, 2, 0, 1'b1, 1'b1);
    wait_drain(1'b1, 200);
    check("full_recover", s_cnt_full, 1);
    check("s_other_err", s_cnt_other, 0);

    rdy_rand = 1'b1;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 40);
        send_block(len, len, 20, 1'b0, 1'b1);
      end else if (r < 9) begin
        len = $urandom_range(1, 30);
        send_block(len, $urandom_range(0, len - 1), 20, 1'b0, 1'b1);
      end else if (!open_blk) begin
        send_stray($urandom_range(1, 3));
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 6));
    end
    if (open_blk) send_block(0, 0, 0, 1'b0, 1'b1);
    wait_drain(1'b0, 8000);
    check_errs("rnd");
    check("rnd_full", cnt_full, 0);

    rdy_rand = 1'b0;
    @(posedge clk); #1 dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("end_valid", {dout_valid, s_dout_valid}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
